lampfpu_div_req_queue: RTL and testbench
========================================

// Module: lampfpu_div_req_queue
// PURPOSE
//  Request queue and sequencer directly upstream of lampFPU_div_top.
//  - Buffers divide requests {op1, op2, rndMode, tag} in a FIFO.
//  - Issues them one at a time over the do_div/isResultValid_o/padv_i protocol.
//  - Returns each tagged result through a single-entry valid/ready output slot.
//  - Frees the CPU from holding operands and rounding mode for the whole divide latency.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >=2)
//  TAG_W  4  request tag width, returned unchanged with the result
// PORTS
//  clk             in   1                 clock
//  rst             in   1                 synchronous reset, active-high
//  req_valid_i     in   1                 request present
//  req_ready_o     out  1                 FIFO can accept
//  req_op1_i       in   LAMP_FLOAT_DW     dividend
//  req_op2_i       in   LAMP_FLOAT_DW     divisor
//  req_rnd_i       in   1                 rounding mode for this request
//  req_tag_i       in   TAG_W             request tag
//  div_do_o        out  1                 to div do_div
//  div_padv_o      out  1                 to div padv_i
//  div_rnd_o       out  1                 to div rndMode_i
//  div_op1_o       out  LAMP_FLOAT_DW     to div op1_i
//  div_op2_o       out  LAMP_FLOAT_DW     to div op2_i
//  div_result_i    in   LAMP_FLOAT_DW     from div result_o
//  div_valid_i     in   1                 from div isResultValid_o
//  div_ready_i     in   1                 from div isReady_o
//  rsp_valid_o     out  1                 result slot full
//  rsp_ready_i     in   1                 consumer takes result
//  rsp_result_o    out  LAMP_FLOAT_DW     quotient
//  rsp_tag_o       out  TAG_W             tag of that quotient
//  count_o         out  $clog2(DEPTH)+1   FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, rsp slot empty.
//  - The div unit shares clk/rst, so reset mid-operation aborts cleanly; the in-flight request is lost.
//  FIFO: push when req_valid_i & req_ready_o; req_ready_o = (count < DEPTH) from the registered count.
//  - When full, there is no same-cycle push even if a pop occurs.
//  - Pointers wrap modulo DEPTH.
//  - Pop only in WAIT on capture. The head entry stays in the FIFO for the whole operation.
//  div_op1_o/div_op2_o/div_rnd_o are driven combinationally from the FIFO head in every state.
//  - The div unit samples rndMode continuously, so the head must stay stable until capture.
//  - Outputs are 0 when the FIFO is empty.
//  FSM, states IDLE, ISSUE, WAIT, DRAIN:
//  - IDLE: go to ISSUE when count>0 & div_ready_i & !div_valid_i.
//  - ISSUE: div_do_o=1 for exactly this one cycle; next state WAIT.
//  - WAIT: if div_valid_i & !rsp_valid_o, then in the same cycle:
//    - load rsp_result_o <= div_result_i and rsp_tag_o <= head tag;
//    - set rsp_valid_o;
//    - div_padv_o=1 (one cycle);
//    - pop the FIFO;
//    - go to DRAIN.
//  - WAIT while rsp_valid_o=1: div_padv_o stays 0 and the div unit holds DONE (backpressure).
//  - DRAIN: one cycle while the div unit returns to IDLE; then IDLE. do_div is never asserted in DRAIN.
//  rsp slot: rsp_valid_o clears on rsp_valid_o & rsp_ready_i.
//  - Capture and consume in the same cycle are impossible, since capture requires the slot empty.
//  - The next issue may proceed while the slot is full; only capture waits.
//  Latency: request accepted in cycle T into an empty FIFO with the div idle.
//  - div_do_o is high at T+2.
//  - rsp_valid_o rises the cycle after div_valid_i is first seen in WAIT.
//  - Back-to-back issue spacing is the div latency plus 3 cycles.
//  Requests are processed strictly in order; tags are never reordered.
// TESTING (IEEE single encodings; LAMP_FLOAT_DW=32)
//  1. Push 6.0/2.0 (0x40C00000/0x40000000, tag 3), rsp_ready_i=1.
//     -> one div_do_o pulse at T+2; rsp 0x40400000, tag 3; one padv pulse; count returns to 0.
//  2. Push 4 requests back-to-back (tags 0..3, 1.0/4.0 each).
//     -> req_ready_o low after the 4th; results 0x3E800000 with tags 0,1,2,3 in order.
//     -> a 5th push is refused until the first pop.
//  3. Hold rsp_ready_i=0 with 2 requests queued.
//     -> first result held; the second divide completes but div_padv_o stays 0 and div_valid_i stays high.
//     -> releasing rsp_ready_i delivers tag order 0 then 1.
//  4. 1.0/0.0 with req_rnd_i=1, then 1.0/3.0 with req_rnd_i=0.
//     -> 0x7F800000, then 0x3EAAAAAB.
//     -> div_rnd_o stable throughout each operation.
//  5. Assert rst while in WAIT with 3 entries queued.
//     -> the next cycle shows count_o=0, rsp_valid_o=0, div_do_o=0, req_ready_o=1.
//     -> a new request afterwards completes normally.
//  6. Push and consume simultaneously at count=DEPTH-1 and at wrap.
//     -> no entry lost or duplicated over 3*DEPTH requests (scoreboard on tags).

Source files
------------

// File: rtl/lampfpu_div_req_queue.sv
// Request FIFO and issue sequencer in front of lampFPU_div_top.
// Buffers tagged divide requests, issues them in order, and returns tagged quotients.
module lampfpu_div_req_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned LAMP_FLOAT_DW = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [LAMP_FLOAT_DW-1:0]     req_op1_i,
  input  logic [LAMP_FLOAT_DW-1:0]     req_op2_i,
  input  logic                         req_rnd_i,
  input  logic [TAG_W-1:0]             req_tag_i,
  output logic                         div_do_o,
  output logic                         div_padv_o,
  output logic                         div_rnd_o,
  output logic [LAMP_FLOAT_DW-1:0]     div_op1_o,
  output logic [LAMP_FLOAT_DW-1:0]     div_op2_o,
  input  logic [LAMP_FLOAT_DW-1:0]     div_result_i,
  input  logic                         div_valid_i,
  input  logic                         div_ready_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [LAMP_FLOAT_DW-1:0]     rsp_result_o,
  output logic [TAG_W-1:0]             rsp_tag_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LAMP_FLOAT_DW-1:0] op1_mem [DEPTH];
  logic [LAMP_FLOAT_DW-1:0] op2_mem [DEPTH];
  logic                     rnd_mem [DEPTH];
  logic [TAG_W-1:0]         tag_mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, capture, not_empty;

  assign req_ready_o = (count < CW'(DEPTH));
  assign push        = req_valid_i & req_ready_o;
  assign capture     = (state == WAIT) & div_valid_i & ~rsp_valid_o;
  assign not_empty   = (count != '0);
  assign count_o     = count;

  // Head entry is held until its result is captured; the div unit reads it live.
  assign div_op1_o = not_empty ? op1_mem[rd_ptr] : '0;
  assign div_op2_o = not_empty ? op2_mem[rd_ptr] : '0;
  assign div_rnd_o = not_empty ? rnd_mem[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      op1_mem[wr_ptr] <= req_op1_i;
      op2_mem[wr_ptr] <= req_op2_i;
      rnd_mem[wr_ptr] <= req_rnd_i;
      tag_mem[wr_ptr] <= req_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (capture) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(capture);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    div_do_o   = 1'b0;
    div_padv_o = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty && div_ready_i && !div_valid_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        div_do_o  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A full result slot stalls the div unit in DONE until the consumer drains it.
        if (capture) begin
          div_padv_o = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_tag_o    <= '0;
    end else if (capture) begin
      rsp_valid_o  <= 1'b1;
      rsp_result_o <= div_result_i;
      rsp_tag_o    <= tag_mem[rd_ptr];
    end else if (rsp_valid_o && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lampfpu_div_req_queue.sv
// Randomized bench for lampfpu_div_req_queue with a behavioural divider and an in-order scoreboard.
module tb_lampfpu_div_req_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned DW    = 32;

  logic            clk, rst;
  logic            req_valid_i, req_ready_o, req_rnd_i;
  logic [DW-1:0]   req_op1_i, req_op2_i;
  logic [TAG_W-1:0] req_tag_i;
  logic            div_do_o, div_padv_o, div_rnd_o;
  logic [DW-1:0]   div_op1_o, div_op2_o, div_result_i;
  logic            div_valid_i, div_ready_i;
  logic            rsp_valid_o, rsp_ready_i;
  logic [DW-1:0]   rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [$clog2(DEPTH):0] count_o;

  lampfpu_div_req_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAMP_FLOAT_DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
    .div_do_o(div_do_o), .div_padv_o(div_padv_o), .div_rnd_o(div_rnd_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_valid_i(div_valid_i), .div_ready_i(div_ready_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    op1;
    logic [DW-1:0]    op2;
    logic             rnd;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    res;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus for the coming clock edge
  logic             t_rst, t_valid, t_rnd, t_rdy;
  logic [DW-1:0]    t_op1, t_op2;
  logic [TAG_W-1:0] t_tag;

  // Reference: requests in flight in order (result-slot entry first), slot occupancy, FIFO count
  ent_t exp_q[$];
  int   ref_count;
  logic ref_rsp;
  logic [TAG_W-1:0] tag_log[$];
  logic [DW-1:0]    res_log[$];
  int   n_cap, n_padv, n_cons;
  logic s_do, s_padv, s_pushed;

  // Behavioural divider: 0 idle, 1 busy, 2 done
  int            dst, dcnt;
  logic [DW-1:0] dres, d_op1;
  logic          d_rnd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] quot(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic r);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
    if (a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
    if (a == 32'h3F800000 && b == 32'h40400000) return 32'h3EAAAAAB;
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, r};
  endfunction

  task automatic cyc();
    ent_t e;
    int   idx;
    logic cap, cons;
    @(negedge clk);
    rst          = t_rst;
    req_valid_i  = t_valid;
    req_op1_i    = t_op1;
    req_op2_i    = t_op2;
    req_rnd_i    = t_rnd;
    req_tag_i    = t_tag;
    rsp_ready_i  = t_rdy;
    div_valid_i  = (dst == 2);
    div_ready_i  = (dst == 0);
    div_result_i = dres;
    #1;
    s_do     = div_do_o;
    s_padv   = div_padv_o;
    s_pushed = 1'b0;
    if (t_rst) begin
      exp_q.delete();
      ref_count = 0;
      ref_rsp   = 1'b0;
      dst       = 0;
      return;
    end
    chk("count", 32'(count_o), 32'(ref_count));
    chk("req_ready", 32'(req_ready_o), 32'(ref_count < DEPTH));
    chk("rsp_valid", 32'(rsp_valid_o), 32'(ref_rsp));
    chk("padv", 32'(div_padv_o), 32'((dst == 2) && !ref_rsp));
    if (dst != 0) chk("do_while_busy", 32'(div_do_o), 32'd0);
    if (dst != 0) begin
      chk("rnd_stable", 32'(div_rnd_o), 32'(d_rnd));
      chk("op1_stable", div_op1_o, d_op1);
    end
    if (ref_count == 0) chk("op1_empty", div_op1_o, 32'd0);
    if (div_padv_o) n_padv++;

    cap  = (dst == 2) && !ref_rsp;
    cons = ref_rsp && t_rdy;
    if (cons) begin
      e = exp_q.pop_front();
      chk("rsp_result", rsp_result_o, e.res);
      chk("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
      tag_log.push_back(rsp_tag_o);
      res_log.push_back(rsp_result_o);
      n_cons++;
    end
    if (t_valid && ref_count < DEPTH) begin
      e.op1 = t_op1; e.op2 = t_op2; e.rnd = t_rnd; e.tag = t_tag;
      e.res = quot(t_op1, t_op2, t_rnd);
      exp_q.push_back(e);
      s_pushed = 1'b1;
    end
    if (cap) n_cap++;
    ref_count = ref_count + (s_pushed ? 1 : 0) - (cap ? 1 : 0);
    ref_rsp   = cap ? 1'b1 : (cons ? 1'b0 : ref_rsp);

    case (dst)
      0: if (div_do_o) begin
        idx = (cons ? 0 : (ref_rsp && !cap ? 1 : 0));
        idx = ref_rsp ? 1 : 0;
        if (cons) idx = 0;
        if (exp_q.size() > idx) begin
          chk("issue_op1", div_op1_o, exp_q[idx].op1);
          chk("issue_op2", div_op2_o, exp_q[idx].op2);
          chk("issue_rnd", 32'(div_rnd_o), 32'(exp_q[idx].rnd));
        end else chk("issue_when_empty", 32'(exp_q.size()), 32'(idx + 1));
        d_op1 = div_op1_o;
        d_rnd = div_rnd_o;
        dres  = quot(div_op1_o, div_op2_o, div_rnd_o);
        dcnt  = $urandom_range(1, 5);
        dst   = 1;
      end
      1: begin
        dcnt--;
        if (dcnt == 0) dst = 2;
      end
      default: if (div_padv_o) dst = 0;
    endcase
  endtask

  task automatic push1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic r,
                       input logic [TAG_W-1:0] tg);
    t_valid = 1'b1; t_op1 = a; t_op2 = b; t_rnd = r; t_tag = tg;
    cyc();
    chk("push_accepted", 32'(s_pushed), 32'd1);
    t_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    t_valid = 1'b0;
    t_rdy   = 1'b1;
    while ((ref_count != 0 || ref_rsp) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(ref_count + (ref_rsp ? 1 : 0)), 32'd0);
  endtask

  task automatic do_reset();
    t_rst = 1'b1; t_valid = 1'b0; t_rdy = 1'b0;
    cyc();
    cyc();
    t_rst = 1'b0;
  endtask

  initial begin
    int p0, acc, n;
    t_rst = 1'b1; t_valid = 1'b0; t_op1 = '0; t_op2 = '0; t_rnd = 1'b0; t_tag = '0; t_rdy = 1'b0;
    rst = 1'b1; req_valid_i = 1'b0; req_op1_i = '0; req_op2_i = '0; req_rnd_i = 1'b0;
    req_tag_i = '0; rsp_ready_i = 1'b0; div_result_i = '0; div_valid_i = 1'b0; div_ready_i = 1'b1;
    ref_count = 0; ref_rsp = 1'b0; dst = 0; dcnt = 0; dres = '0; d_op1 = '0; d_rnd = 1'b0;
    n_cap = 0; n_padv = 0; n_cons = 0;

    do_reset();
    cyc();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_do", 32'(div_do_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);

    // 1: single 6/2, issue two cycles after acceptance
    t_rdy = 1'b1; tag_log.delete(); res_log.delete(); p0 = n_padv;
    push1(32'h40C00000, 32'h40000000, 1'b0, 4'd3);
    cyc(); chk("t1_do_t1", 32'(s_do), 32'd0);
    cyc(); chk("t1_do_t2", 32'(s_do), 32'd1);
    drain(100);
    chk("t1_nrsp", 32'(res_log.size()), 32'd1);
    if (res_log.size() == 1) begin
      chk("t1_res", res_log[0], 32'h40400000);
      chk("t1_tag", 32'(tag_log[0]), 32'd3);
    end
    chk("t1_padv_pulses", 32'(n_padv - p0), 32'd1);
    chk("t1_count_end", 32'(count_o), 32'd0);

    // 2: fill the FIFO, fifth push refused until first pop
    tag_log.delete(); res_log.delete();
    for (int i = 0; i < 4; i++) push1(32'h3F800000, 32'h40800000, 1'b0, 4'(i));
    p0 = n_cap;
    t_valid = 1'b1; t_tag = 4'd4;
    cyc();
    chk("t2_full_ready", 32'(req_ready_o), 32'd0);
    n = 0;
    while (!s_pushed && n < 100) begin cyc(); n++; end
    t_valid = 1'b0;
    chk("t2_5th_accepted", 32'(s_pushed), 32'd1);
    chk("t2_5th_after_pop", 32'(n_cap > p0), 32'd1);
    drain(300);
    chk("t2_nrsp", 32'(tag_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < tag_log.size(); i++) begin
      chk("t2_tag_order", 32'(tag_log[i]), 32'(i));
      chk("t2_res", res_log[i], 32'h3E800000);
    end

    // 3: consumer backpressure
    tag_log.delete(); res_log.delete(); t_rdy = 1'b0; p0 = n_padv;
    push1(32'h3F800000, 32'h40800000, 1'b1, 4'd0);
    push1(32'h3F800000, 32'h40800000, 1'b0, 4'd1);
    repeat (40) cyc();
    chk("t3_rsp_held", 32'(rsp_valid_o), 32'd1);
    chk("t3_held_tag", 32'(rsp_tag_o), 32'd0);
    chk("t3_count", 32'(count_o), 32'd1);
    chk("t3_div_done", 32'(div_valid_i), 32'd1);
    chk("t3_no_padv", 32'(s_padv), 32'd0);
    chk("t3_one_padv", 32'(n_padv - p0), 32'd1);
    drain(200);
    chk("t3_nrsp", 32'(tag_log.size()), 32'd2);
    if (tag_log.size() == 2) begin
      chk("t3_tag0", 32'(tag_log[0]), 32'd0);
      chk("t3_tag1", 32'(tag_log[1]), 32'd1);
    end

    // 4: rounding mode held per operation
    tag_log.delete(); res_log.delete(); t_rdy = 1'b1;
    push1(32'h3F800000, 32'h00000000, 1'b1, 4'd5);
    push1(32'h3F800000, 32'h40400000, 1'b0, 4'd6);
    drain(200);
    chk("t4_nrsp", 32'(res_log.size()), 32'd2);
    if (res_log.size() == 2) begin
      chk("t4_inf", res_log[0], 32'h7F800000);
      chk("t4_third", res_log[1], 32'h3EAAAAAB);
    end

    // 5: reset while an operation is in flight
    for (int i = 0; i < 3; i++) push1(32'h3F800000, 32'h40800000, 1'b0, 4'(8 + i));
    n = 0;
    while (dst != 1 && n < 50) begin cyc(); n++; end
    chk("t5_reached_wait", 32'(dst), 32'd1);
    t_rst = 1'b1; cyc(); t_rst = 1'b0;
    cyc();
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("t5_do", 32'(div_do_o), 32'd0);
    chk("t5_ready", 32'(req_ready_o), 32'd1);
    tag_log.delete(); res_log.delete();
    push1(32'h40C00000, 32'h40000000, 1'b0, 4'd7);
    drain(100);
    chk("t5_nrsp", 32'(tag_log.size()), 32'd1);
    if (tag_log.size() == 1) chk("t5_tag", 32'(tag_log[0]), 32'd7);

    // 6: random push/consume traffic across pointer wrap
    p0 = n_cons; acc = 0; n = 0;
    while (acc < 3 * DEPTH * 4 && n < 5000) begin
      t_valid = ($urandom_range(0, 9) < 7);
      t_rdy   = ($urandom_range(0, 9) < 6);
      t_op1   = $urandom; t_op2 = $urandom; t_rnd = 1'($urandom_range(0, 1));
      t_tag   = 4'($urandom_range(0, 15));
      cyc();
      if (s_pushed) acc++;
      n++;
    end
    chk("t6_all_accepted", 32'(acc), 32'(3 * DEPTH * 4));
    drain(1000);
    chk("t6_all_returned", 32'(n_cons - p0), 32'(acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
